// File: rtl/aemb_pkg.sv
// Shared definitions for the AEMB write-back controller: widths, state encoding
// and result-source indices.
package aemb_pkg;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_SWEEP = 2'd1,
    ST_RUN   = 2'd2
  } wb_state_t;

  localparam int unsigned SRC_LD  = 0;
  localparam int unsigned SRC_XL  = 1;
  localparam int unsigned SRC_MUL = 2;
  localparam int unsigned SRC_ALU = 3;
  localparam int unsigned NSRC    = 4;
endpackage

// File: rtl/aemb_wbctl_sb.sv
// Pending-result scoreboard for r1..r31 with one set port, one clear port and
// three hazard lookup ports. r0 has no entry and never reports pending.
module aemb_wbctl_sb
  import aemb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  input  logic [AW-1:0] rd_c,
  output logic          hit
);
  localparam int unsigned NREG = 1 << AW;

  logic [NREG-1:1] busy;
  logic [NREG-1:1] busy_d;

  // Set is applied after clear so a same-cycle issue to the register wins.
  always_comb begin
    busy_d = busy;
    hit    = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (clr_en && (clr_rd == AW'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_rd == AW'(i))) busy_d[i] = 1'b1;
      if (busy[i] && ((rd_a == AW'(i)) || (rd_b == AW'(i)) || (rd_c == AW'(i))))
        hit = 1'b1;
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) busy <= '0;
    else       busy <= busy_d;
  end
endmodule

// File: rtl/aemb_wbctl.sv
// AEMB register-file write-back controller: fixed-priority result arbitration,
// RAW scoreboard and optional post-reset zeroing sweep (AEMB_WBCTL_SWEEP_EN).
module aemb_wbctl
  import aemb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_dat,
  output logic          ld_ack,
  input  logic          xl_req,
  input  logic [AW-1:0] xl_rd,
  input  logic [DW-1:0] xl_dat,
  output logic          xl_ack,
  input  logic          mul_req,
  input  logic [AW-1:0] mul_rd,
  input  logic [DW-1:0] mul_dat,
  output logic          mul_ack,
  input  logic          alu_req,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_dat,
  output logic          alu_ack,
  input  logic          iss_vld,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] d_ra,
  input  logic [AW-1:0] d_rb,
  input  logic [AW-1:0] d_rd,
  output logic          d_hzd,
  output logic          w_wre,
  output logic [AW-1:0] w_rw,
  output logic [DW-1:0] w_dat,
  output logic          init_done
);
  wb_state_t       state, state_d;
  logic [NSRC-1:0] src_req, ack;
  logic [AW-1:0]   src_rd  [NSRC];
  logic [DW-1:0]   src_dat [NSRC];
  logic            gnt;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_dat;
  logic            wre_d;
  logic [AW-1:0]   rw_d;
  logic [DW-1:0]   dat_d;
  logic            run;
  logic            sb_hit;
`ifdef AEMB_WBCTL_SWEEP_EN
  logic [AW-1:0]   cnt, cnt_d;
`endif

  assign src_req[SRC_LD]  = ld_req;  assign src_rd[SRC_LD]  = ld_rd;  assign src_dat[SRC_LD]  = ld_dat;
  assign src_req[SRC_XL]  = xl_req;  assign src_rd[SRC_XL]  = xl_rd;  assign src_dat[SRC_XL]  = xl_dat;
  assign src_req[SRC_MUL] = mul_req; assign src_rd[SRC_MUL] = mul_rd; assign src_dat[SRC_MUL] = mul_dat;
  assign src_req[SRC_ALU] = alu_req; assign src_rd[SRC_ALU] = alu_rd; assign src_dat[SRC_ALU] = alu_dat;

  assign ld_ack  = ack[SRC_LD];
  assign xl_ack  = ack[SRC_XL];
  assign mul_ack = ack[SRC_MUL];
  assign alu_ack = ack[SRC_ALU];

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Lowest source index has the highest priority.
  always_comb begin
    ack     = '0;
    gnt     = 1'b0;
    gnt_rd  = '0;
    gnt_dat = '0;
    if (run && gena) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (!gnt && src_req[k]) begin
          gnt     = 1'b1;
          ack[k]  = 1'b1;
          gnt_rd  = src_rd[k];
          gnt_dat = src_dat[k];
        end
      end
    end
  end

  // The sweep ends on the cycle after r31 is on the write port, so RUN (and
  // init_done) start one cycle after the last sweep write.
  always_comb begin
    state_d = state;
    wre_d   = 1'b0;
    rw_d    = w_rw;
    dat_d   = w_dat;
`ifdef AEMB_WBCTL_SWEEP_EN
    cnt_d   = cnt;
`endif
    unique case (state)
`ifdef AEMB_WBCTL_SWEEP_EN
      ST_RST, ST_SWEEP: begin
        if (w_wre && (w_rw == '1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SWEEP;
          wre_d   = 1'b1;
          rw_d    = cnt;
          dat_d   = '0;
          cnt_d   = cnt + 1'b1;
        end
      end
`else
      ST_RST, ST_SWEEP: state_d = ST_RUN;
`endif
      ST_RUN: begin
        if (gnt) begin
          wre_d = (gnt_rd != '0);
          rw_d  = gnt_rd;
          dat_d = gnt_dat;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state <= ST_RST;
      w_wre <= 1'b0;
      w_rw  <= '0;
      w_dat <= '0;
`ifdef AEMB_WBCTL_SWEEP_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_d;
      w_wre <= wre_d;
      w_rw  <= rw_d;
      w_dat <= dat_d;
`ifdef AEMB_WBCTL_SWEEP_EN
      cnt   <= cnt_d;
`endif
    end
  end

  aemb_wbctl_sb #(.AW(AW)) u_sb (
    .gclk   (gclk),
    .grst   (grst),
    .set_en (iss_vld && gena && run),
    .set_rd (iss_rd),
    .clr_en (gnt),
    .clr_rd (gnt_rd),
    .rd_a   (d_ra),
    .rd_b   (d_rb),
    .rd_c   (d_rd),
    .hit    (sb_hit)
  );

`ifdef AEMB_WBCTL_SWEEP_EN
  assign d_hzd = sb_hit || !run;
`else
  assign d_hzd = sb_hit;
`endif
endmodule

// File: tb/tb_aemb_wbctl.sv
// Self-checking bench for aemb_wbctl: directed scenarios plus a randomized run
// against a register-level pending/priority model.
module tb_aemb_wbctl;
  import aemb_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          gclk = 1'b0;
  logic          grst = 1'b0;
  logic          gena;
  logic          req_v [4];
  logic [AW-1:0] rd_v  [4];
  logic [DW-1:0] dat_v [4];
  logic [3:0]    ack_v;
  logic          ld_ack, xl_ack, mul_ack, alu_ack;
  logic          iss_vld;
  logic [AW-1:0] iss_rd, d_ra, d_rb, d_rd;
  logic          d_hzd, w_wre, init_done;
  logic [AW-1:0] w_rw;
  logic [DW-1:0] w_dat;

  int checks   = 0;
  int failures = 0;

  always #5 gclk = ~gclk;

  assign ack_v[SRC_LD]  = ld_ack;
  assign ack_v[SRC_XL]  = xl_ack;
  assign ack_v[SRC_MUL] = mul_ack;
  assign ack_v[SRC_ALU] = alu_ack;

  aemb_wbctl #(.AW(AW), .DW(DW)) dut (
    .gclk(gclk), .grst(grst), .gena(gena),
    .ld_req(req_v[SRC_LD]),   .ld_rd(rd_v[SRC_LD]),   .ld_dat(dat_v[SRC_LD]),   .ld_ack(ld_ack),
    .xl_req(req_v[SRC_XL]),   .xl_rd(rd_v[SRC_XL]),   .xl_dat(dat_v[SRC_XL]),   .xl_ack(xl_ack),
    .mul_req(req_v[SRC_MUL]), .mul_rd(rd_v[SRC_MUL]), .mul_dat(dat_v[SRC_MUL]), .mul_ack(mul_ack),
    .alu_req(req_v[SRC_ALU]), .alu_rd(rd_v[SRC_ALU]), .alu_dat(dat_v[SRC_ALU]), .alu_ack(alu_ack),
    .iss_vld(iss_vld), .iss_rd(iss_rd),
    .d_ra(d_ra), .d_rb(d_rb), .d_rd(d_rd), .d_hzd(d_hzd),
    .w_wre(w_wre), .w_rw(w_rw), .w_dat(w_dat), .init_done(init_done)
  );

  task automatic idle();
    for (int k = 0; k < 4; k++) begin
      req_v[k] = 1'b0; rd_v[k] = '0; dat_v[k] = '0;
    end
    gena = 1'b1; iss_vld = 1'b0; iss_rd = '0;
    d_ra = '0; d_rb = '0; d_rd = '0;
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int unsigned s);
    logic [3:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      req_v[k] = 1'b1; rd_v[k] = AW'(k + 1); dat_v[k] = 32'hDEAD_0000 + DW'(k);
    end
    gena = 1'b1; iss_vld = 1'b1; iss_rd = 5'd3; d_ra = 5'd3;
    grst = 1'b0;
    step(); step();
    checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL rst_wre got=%b exp=0", w_wre); end
    checks++; if (w_rw !== '0) begin failures++; $display("FAIL rst_rw got=%0d exp=0", w_rw); end
    checks++; if (w_dat !== '0) begin failures++; $display("FAIL rst_dat got=%h exp=0", w_dat); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init got=%b exp=0", init_done); end
    checks++; if (ack_v !== 4'b0) begin failures++; $display("FAIL rst_acks got=%b exp=0000", ack_v); end
`ifdef AEMB_WBCTL_SWEEP_EN
    checks++; if (d_hzd !== 1'b1) begin failures++; $display("FAIL rst_hzd got=%b exp=1", d_hzd); end
`else
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL rst_hzd got=%b exp=0", d_hzd); end
`endif
    idle();
    @(negedge gclk);
    grst = 1'b1;
  endtask

  // Entered just after grst release, before the first active edge.
  task automatic test_sweep();
`ifdef AEMB_WBCTL_SWEEP_EN
    for (int k = 0; k < 4; k++) begin
      req_v[k] = 1'b1; rd_v[k] = AW'(k + 20); dat_v[k] = 32'h1111_1111 * DW'(k + 1);
    end
    iss_vld = 1'b1; iss_rd = 5'd5; d_ra = 5'd5;
    #1;
    checks++; if (ack_v !== 4'b0) begin failures++; $display("FAIL sweep_ack0 got=%b exp=0000", ack_v); end
    for (int k = 0; k < 32; k++) begin
      step();
      checks++; if (w_wre !== 1'b1) begin failures++; $display("FAIL sweep_wre idx=%0d got=%b exp=1", k, w_wre); end
      checks++; if (w_rw !== AW'(k)) begin failures++; $display("FAIL sweep_rw got=%0d exp=%0d", w_rw, k); end
      checks++; if (w_dat !== '0) begin failures++; $display("FAIL sweep_dat idx=%0d got=%h exp=0", k, w_dat); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL sweep_init idx=%0d got=%b exp=0", k, init_done); end
      checks++; if (ack_v !== 4'b0) begin failures++; $display("FAIL sweep_acks idx=%0d got=%b exp=0000", k, ack_v); end
      checks++; if (d_hzd !== 1'b1) begin failures++; $display("FAIL sweep_hzd idx=%0d got=%b exp=1", k, d_hzd); end
    end
    step();
    idle();
    d_ra = 5'd5;
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL sweep_done got=%b exp=1", init_done); end
    checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL sweep_end_wre got=%b exp=0", w_wre); end
    #1;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL sweep_iss_ignored got=%b exp=0", d_hzd); end
`else
    step();
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL nosweep_init got=%b exp=1", init_done); end
    checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL nosweep_wre got=%b exp=0", w_wre); end
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL nosweep_hzd got=%b exp=0", d_hzd); end
`endif
    idle();
  endtask

  task automatic test_priority();
    req_v[SRC_LD]  = 1'b1; rd_v[SRC_LD]  = 5'd3; dat_v[SRC_LD]  = 32'hAAAA_0000;
    req_v[SRC_ALU] = 1'b1; rd_v[SRC_ALU] = 5'd4; dat_v[SRC_ALU] = 32'h0000_5555;
    #1;
    checks++; if (ack_v !== onehot(SRC_LD)) begin failures++; $display("FAIL prio_first got=%b exp=%b", ack_v, onehot(SRC_LD)); end
    step();
    req_v[SRC_LD] = 1'b0;
    checks++; if ({w_wre, w_rw, w_dat} !== {1'b1, 5'd3, 32'hAAAA_0000}) begin failures++; $display("FAIL prio_wr_r3 got=%b/%0d/%h exp=1/3/aaaa0000", w_wre, w_rw, w_dat); end
    #1;
    checks++; if (ack_v !== onehot(SRC_ALU)) begin failures++; $display("FAIL prio_second got=%b exp=%b", ack_v, onehot(SRC_ALU)); end
    step();
    req_v[SRC_ALU] = 1'b0;
    checks++; if ({w_wre, w_rw, w_dat} !== {1'b1, 5'd4, 32'h0000_5555}) begin failures++; $display("FAIL prio_wr_r4 got=%b/%0d/%h exp=1/4/00005555", w_wre, w_rw, w_dat); end
    step();
    checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL prio_idle_wre got=%b exp=0", w_wre); end
    idle();
  endtask

  task automatic test_hazard();
    d_ra = 5'd7; iss_vld = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL hzd_before got=%b exp=0", d_hzd); end
    step();
    iss_vld = 1'b0;
    checks++; if (d_hzd !== 1'b1) begin failures++; $display("FAIL hzd_set got=%b exp=1", d_hzd); end
    step();
    checks++; if (d_hzd !== 1'b1) begin failures++; $display("FAIL hzd_hold got=%b exp=1", d_hzd); end
    req_v[SRC_MUL] = 1'b1; rd_v[SRC_MUL] = 5'd7; dat_v[SRC_MUL] = 32'h1234_5678;
    #1;
    checks++; if ({ack_v, d_hzd} !== {onehot(SRC_MUL), 1'b1}) begin failures++; $display("FAIL hzd_mul_ack got=%b/%b exp=%b/1", ack_v, d_hzd, onehot(SRC_MUL)); end
    step();
    req_v[SRC_MUL] = 1'b0;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL hzd_clear got=%b exp=0", d_hzd); end
    checks++; if ({w_wre, w_rw, w_dat} !== {1'b1, 5'd7, 32'h1234_5678}) begin failures++; $display("FAIL hzd_wr_r7 got=%b/%0d/%h exp=1/7/12345678", w_wre, w_rw, w_dat); end
    idle();
  endtask

  task automatic test_collision();
    d_rb = 5'd9;
    req_v[SRC_ALU] = 1'b1; rd_v[SRC_ALU] = 5'd9; dat_v[SRC_ALU] = 32'h0000_0099;
    iss_vld = 1'b1; iss_rd = 5'd9;
    #1;
    checks++; if (ack_v !== onehot(SRC_ALU)) begin failures++; $display("FAIL coll_ack got=%b exp=%b", ack_v, onehot(SRC_ALU)); end
    step();
    iss_vld = 1'b0;
    checks++; if (d_hzd !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", d_hzd); end
    checks++; if ({w_wre, w_rw} !== {1'b1, 5'd9}) begin failures++; $display("FAIL coll_wr got=%b/%0d exp=1/9", w_wre, w_rw); end
    step();
    req_v[SRC_ALU] = 1'b0;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", d_hzd); end
    idle();
  endtask

  task automatic test_r0_gena();
    req_v[SRC_ALU] = 1'b1; rd_v[SRC_ALU] = 5'd0; dat_v[SRC_ALU] = 32'hFFFF_FFFF;
    iss_vld = 1'b1; iss_rd = 5'd0;
    #1;
    checks++; if (ack_v !== onehot(SRC_ALU)) begin failures++; $display("FAIL r0_ack got=%b exp=%b", ack_v, onehot(SRC_ALU)); end
    step();
    req_v[SRC_ALU] = 1'b0; iss_vld = 1'b0;
    checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL r0_no_write got=%b exp=0", w_wre); end
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL r0_never_busy got=%b exp=0", d_hzd); end
    iss_vld = 1'b1; iss_rd = 5'd5;
    step();
    gena = 1'b0; iss_rd = 5'd6;
    req_v[SRC_LD] = 1'b1; rd_v[SRC_LD] = 5'd5; dat_v[SRC_LD] = 32'h0BAD_F00D;
    d_ra = 5'd5; d_rb = 5'd6;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if ({ack_v, d_hzd} !== {4'b0, 1'b1}) begin failures++; $display("FAIL gena0_freeze n=%0d got=%b/%b exp=0000/1", n, ack_v, d_hzd); end
      step();
      checks++; if (w_wre !== 1'b0) begin failures++; $display("FAIL gena0_wre n=%0d got=%b exp=0", n, w_wre); end
    end
    d_ra = 5'd0;
    #1;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL gena0_no_set got=%b exp=0", d_hzd); end
    d_ra = 5'd5; iss_vld = 1'b0; gena = 1'b1;
    #1;
    checks++; if (ack_v !== onehot(SRC_LD)) begin failures++; $display("FAIL gena1_ack got=%b exp=%b", ack_v, onehot(SRC_LD)); end
    step();
    req_v[SRC_LD] = 1'b0;
    checks++; if ({w_wre, w_rw, w_dat, d_hzd} !== {1'b1, 5'd5, 32'h0BAD_F00D, 1'b0}) begin failures++; $display("FAIL gena1_wr got=%b/%0d/%h/%b exp=1/5/0badf00d/0", w_wre, w_rw, w_dat, d_hzd); end
    idle();
  endtask

  task automatic test_mid_reset();
    bit hit12;
    iss_vld = 1'b1; iss_rd = 5'd10;
    req_v[SRC_ALU] = 1'b1; rd_v[SRC_ALU] = 5'd11; dat_v[SRC_ALU] = 32'h0000_0011;
    step();
    idle();
    grst = 1'b0;
    #1;
    checks++; if ({w_wre, w_rw, w_dat, init_done} !== '0) begin failures++; $display("FAIL midrun_rst got=%b/%0d/%h/%b exp=0/0/0/0", w_wre, w_rw, w_dat, init_done); end
    @(negedge gclk);
    grst = 1'b1;
`ifdef AEMB_WBCTL_SWEEP_EN
    hit12 = 1'b0;
    for (int n = 0; n < 40 && !hit12; n++) begin
      step();
      if (w_wre && w_rw == 5'd12) hit12 = 1'b1;
    end
    checks++; if (hit12 !== 1'b1) begin failures++; $display("FAIL midsweep_reach12 got=%b exp=1", hit12); end
    grst = 1'b0;
    #1;
    checks++; if ({w_wre, w_rw, init_done} !== '0) begin failures++; $display("FAIL midsweep_rst got=%b/%0d/%b exp=0/0/0", w_wre, w_rw, init_done); end
    @(negedge gclk);
    grst = 1'b1;
    test_sweep();
`else
    hit12 = 1'b1;
    test_sweep();
`endif
    d_ra = 5'd10;
    #1;
    checks++; if (d_hzd !== 1'b0) begin failures++; $display("FAIL midrst_busy_clr got=%b exp=0 hit=%b", d_hzd, hit12); end
    idle();
  endtask

  task automatic test_random();
    bit            mbusy [32];
    int            prio [4];
    int            win;
    logic [3:0]    exp_ack;
    logic          exp_hzd, exp_wre;
    logic [AW-1:0] exp_rw;
    logic [DW-1:0] exp_dat;
    prio = '{SRC_LD, SRC_XL, SRC_MUL, SRC_ALU};
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    exp_wre = 1'b0; exp_rw = '0; exp_dat = '0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++)
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          req_v[k] = 1'b1; rd_v[k] = AW'($urandom_range(0, 7)); dat_v[k] = $urandom;
        end
      gena    = ($urandom_range(0, 4) != 0);
      iss_vld = $urandom_range(0, 1) != 0;
      iss_rd  = AW'($urandom_range(0, 7));
      d_ra = AW'($urandom_range(0, 7)); d_rb = AW'($urandom_range(0, 7)); d_rd = AW'($urandom_range(0, 31));
      #1;
      win = -1;
      if (gena)
        for (int p = 0; p < 4; p++)
          if (win < 0 && req_v[prio[p]]) win = prio[p];
      exp_ack = (win >= 0) ? onehot(win) : 4'b0;
      exp_hzd = mbusy[d_ra] | mbusy[d_rb] | mbusy[d_rd];
      checks++; if (ack_v !== exp_ack) begin failures++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, ack_v, exp_ack); end
      checks++; if (d_hzd !== exp_hzd) begin failures++; $display("FAIL rnd_hzd n=%0d got=%b exp=%b", n, d_hzd, exp_hzd); end
      exp_wre = (win >= 0) && (rd_v[win] != 0);
      if (win >= 0) begin
        exp_rw = rd_v[win]; exp_dat = dat_v[win];
        mbusy[rd_v[win]] = 1'b0;
      end
      if (iss_vld && gena && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      step();
      if (win >= 0) req_v[win] = 1'b0;
      checks++; if (w_wre !== exp_wre) begin failures++; $display("FAIL rnd_wre n=%0d got=%b exp=%b", n, w_wre, exp_wre); end
      if (exp_wre) begin
        checks++; if ({w_rw, w_dat} !== {exp_rw, exp_dat}) begin failures++; $display("FAIL rnd_wr n=%0d got=%0d/%h exp=%0d/%h", n, w_rw, w_dat, exp_rw, exp_dat); end
      end
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_sweep();
    test_priority();
    test_hazard();
    test_collision();
    test_r0_gena();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
